// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_hs.sv
// Half subtractor: one bit of x - y with its borrow.
module hs (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor (a - b), LSB first, one bit per clock.
// Optional macro SERIAL_SUB_SAT_EN clamps diff to zero on underflow.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CNT_W-1:0] cnt;
  logic             bw;
  logic             d1, bo1, d_bit, bo2, bw_next, last_bit;

  // Full subtractor built from two half subtractors.
  hs u_hs_ab (.x(a_sr[0]), .y(b_sr[0]), .d(d1),    .bo(bo1));
  hs u_hs_bw (.x(d1),      .y(bw),      .d(d_bit), .bo(bo2));

  assign bw_next  = bo1 | bo2;
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result bits enter at the MSB so bit 0 lands at diff[0] after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      cnt        <= '0;
      bw         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            bw   <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          bw   <= bw_next;
          cnt  <= cnt + CNT_W'(1);
          diff <= {d_bit, diff[WIDTH-1:1]};
          if (last_bit) begin
            borrow_out <= bw_next;
`ifdef SERIAL_SUB_SAT_EN
            if (bw_next) diff <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: timeline reference model plus directed checks.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  int n_compared   = 0;
  int n_mismatched = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: each accepted operation occupies a fixed window of edges
  // after the accepting edge; the result is plain unsigned arithmetic.
  int           edge_n;
  int           acc_n;
  bit           active;
  logic [W-1:0] pend_diff, held_diff;
  logic         pend_bw, held_bw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n    = 0;
      acc_n     = 0;
      active    = 0;
      held_diff = '0;
      held_bw   = 1'b0;
    end else begin
      edge_n = edge_n + 1;
      if (start && (!active || edge_n >= acc_n + W + 2)) begin
        active    = 1;
        acc_n     = edge_n;
        pend_bw   = (a < b);
        pend_diff = W'(int'(a) - int'(b));
`ifdef SERIAL_SUB_SAT_EN
        if (pend_bw) pend_diff = '0;
`endif
      end
      if (active && edge_n == acc_n + W) begin
        held_diff = pend_diff;
        held_bw   = pend_bw;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled mid-cycle.
  bit exp_busy, exp_done, in_shift;
  int neg_n = 0;
  always @(negedge clk) begin
    neg_n++;
    if (rst_n) begin
      exp_busy = active && edge_n >= acc_n && edge_n <= acc_n + W;
      exp_done = active && edge_n == acc_n + W;
      in_shift = active && edge_n >= acc_n && edge_n < acc_n + W;
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("done", 32'(done), 32'(exp_done));
      if (!in_shift) begin
        checkOutput("diff_model", 32'(diff), 32'(held_diff));
        checkOutput("borrow_model", 32'(borrow_out), 32'(held_bw));
      end
    end
  end

  // Drive a one-cycle start; returns just after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
    @(negedge clk);
    #1;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    if (!hold) start = 1'b0;
  endtask

  task automatic waitDone(output int waited, output int at_neg);
    waited = 0;
    at_neg = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        waited = k;
        at_neg = neg_n;
        return;
      end
    end
    checkOutput("done_timeout", 32'd0, 32'd1);
    waited = -1;
  endtask

  int wcyc, t1, t2;
  logic [W-1:0] sat_exp;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_diff", 32'(diff), 32'd0);
    checkOutput("reset_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 5 - 3: done arrives W cycles after the accepting edge
    applyStimulus(8'h05, 8'h03, 0);
    waitDone(wcyc, t1);
    checkOutput("latency_5m3", 32'(wcyc), 32'(W));
    checkOutput("diff_5m3", 32'(diff), 32'h02);
    checkOutput("borrow_5m3", 32'(borrow_out), 32'd0);

    // 3 - 5 underflows
    applyStimulus(8'h03, 8'h05, 0);
    waitDone(wcyc, t1);
`ifdef SERIAL_SUB_SAT_EN
    sat_exp = 8'h00;
`else
    sat_exp = 8'hFE;
`endif
    checkOutput("diff_3m5", 32'(diff), 32'(sat_exp));
    checkOutput("borrow_3m5", 32'(borrow_out), 32'd1);

    // Back-to-back with start held; inputs changed right after acceptance
    applyStimulus(8'hFF, 8'h01, 1);
    a = 8'h00;
    b = 8'h00;
    waitDone(wcyc, t1);
    checkOutput("diff_ffm1", 32'(diff), 32'hFE);
    waitDone(wcyc, t2);
    #1;
    start = 1'b0;
    checkOutput("diff_0m0", 32'(diff), 32'h00);
    checkOutput("borrow_0m0", 32'(borrow_out), 32'd0);
    checkOutput("done_spacing", 32'(t2 - t1), 32'(W + 2));

    // Start during SHIFT must be ignored
    applyStimulus(8'h05, 8'h03, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    a     = 8'hAA;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(wcyc, t1);
    checkOutput("diff_ignored_start", 32'(diff), 32'h02);

    // Reset mid-operation aborts it
    applyStimulus(8'h05, 8'h03, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    applyStimulus(8'h80, 8'h01, 0);
    waitDone(wcyc, t1);
    checkOutput("diff_80m1", 32'(diff), 32'h7F);
    checkOutput("borrow_80m1", 32'(borrow_out), 32'd0);

    // Random traffic: start, a and b change freely every cycle
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
    end
    @(negedge clk);
    #1;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width; legal values are 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  SHALL be the minuend; captured on the accepting edge.
REQ-006 b  input  WIDTH  SHALL be the subtrahend; captured on the accepting edge.
REQ-007 busy  output  1  SHALL be high while in SHIFT or DONE.
REQ-008 done  output  1  SHALL be a one-cycle pulse marking the result valid.
REQ-009 diff  output  WIDTH  SHALL carry the result of a minus b, modulo 2^WIDTH.
REQ-010 borrow_out  output  1  SHALL be high when a < b (unsigned).

Function
REQ-011 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 at edge E0 SHALL latch a and b into shift registers, clear the borrow flop and bit counter, and go to SHIFT.
REQ-013 Each SHIFT edge SHALL process one bit, LSB first: d_i = a_i ^ b_i ^ bw; bw_next = (~a_i & b_i) | (~(a_i ^ b_i) & bw).
REQ-014 Each d_i SHALL shift into diff from the MSB side, so that after WIDTH edges diff[0] holds bit 0.
REQ-015 SHIFT SHALL last exactly WIDTH edges (E0+1 .. E0+WIDTH); counter width is $clog2(WIDTH).
REQ-016 At edge E0+WIDTH the FSM SHALL enter DONE, load borrow_out from the final bw, and assert done for that one cycle.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge; done deasserts there.
REQ-018 diff and borrow_out SHALL hold their values from DONE until the next accepted start; diff is not valid while in SHIFT.
REQ-019 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-020 start held high continuously SHALL begin a new operation on the first edge in IDLE after DONE, giving a WIDTH+2 cycle period.
REQ-021 Changes on a and b after the accepting edge SHALL NOT affect the result in progress.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, busy=0, done=0, diff=0, borrow_out=0, and clear the counter, borrow flop and shift registers.
REQ-023 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after reset release is accepted normally.

Configuration
REQ-024 With macro SERIAL_SUB_SAT_EN defined, the DONE-entry edge SHALL force diff to 0 when the final borrow is 1; borrow_out still reports 1.
REQ-025 Without SERIAL_SUB_SAT_EN, diff SHALL be the wrapped modulo-2^WIDTH result; no saturation logic is synthesized.

Structure
REQ-026 Shared package serial_sub_pkg SHALL hold the state enum typedef (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-027 The per-bit datapath SHALL be two instances of sub-module hs (half subtractor: d = x ^ y, bo = ~x & y), with the two borrows ORed; the FSM, counter and shift registers stay in serial_sub.

Verification (WIDTH=8)
REQ-028 a=0x05, b=0x03, start pulse at E0 -> busy high from E0; done high in the single cycle after E0+8; diff=0x02, borrow_out=0.
REQ-029 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; with SERIAL_SUB_SAT_EN, diff=0x00, borrow_out=1.
REQ-030 a=0xFF, b=0x01, then a=0x00, b=0x00 back-to-back with start held high -> diff=0xFE, then diff=0x00; the two done pulses are exactly 10 cycles apart.
REQ-031 start pulsed again at E0+3 with a=0xAA -> ignored; result remains 0x05 - 0x03 = 0x02.
REQ-032 rst_n low at E0+4 -> immediately busy=0, diff=0, no done pulse; after release, a=0x80, b=0x01 -> diff=0x7F, borrow_out=0.
